// File: rtl/spi_slave_core.sv
// spi_slave_core
// SPI mode 0 (CPOL=0, CPHA=0) slave shift engine, MSB first. Its inputs are
// SCLK, MOSI and CS_n after they have been synchronized to clk_i. It
// exchanges whole frames with host logic through a single-entry TX holding
// buffer and a one-cycle RX strobe.
//
// Ports
//   clk_i         system clock; all state changes on its rising edge
//   rst_i         asynchronous active-high reset
//   sclk_sync_i   synchronized SCLK
//   mosi_sync_i   synchronized MOSI
//   cs_n_sync_i   synchronized active-low chip select
//   miso_o        serial data out (0 while deselected)
//   miso_oe_o     pad output-enable, high while selected
//   tx_data_i     next frame to transmit
//   tx_valid_i    write strobe for tx_data_i
//   tx_ready_o    holding buffer is empty
//   rx_data_o     last completed received frame
//   rx_valid_o    one-cycle pulse when rx_data_o has been updated
//   tx_underrun_o one-cycle pulse when a frame loads from an empty buffer
//   busy_o        high while a chip-select window is active
module spi_slave_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sclk_sync_i,
  input  logic             mosi_sync_i,
  input  logic             cs_n_sync_i,
  output logic             miso_o,
  output logic             miso_oe_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             tx_underrun_o,
  output logic             busy_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic               sclk_q, cs_q;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               reload_q, reload_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               underrun_q, underrun_d;

  logic               sclk_rise, sclk_fall, cs_fall;
  logic               load;
  logic [WIDTH-1:0]   rx_next;

  assign sclk_rise = sclk_sync_i & ~sclk_q;
  assign sclk_fall = ~sclk_sync_i & sclk_q;
  assign cs_fall   = ~cs_n_sync_i & cs_q;
  assign rx_next   = {rx_shift_q[WIDTH-2:0], mosi_sync_i};

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a falling chip select opens a frame window, a high chip
  // select closes it from anywhere inside the window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall)     state_d = ACTIVE;
      ACTIVE:  if (cs_n_sync_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; MISO is forced low while deselected.
  always_comb begin
    miso_oe_o = 1'b0;
    miso_o    = 1'b0;
    busy_o    = 1'b0;
    if (state_q == ACTIVE) begin
      miso_oe_o = 1'b1;
      miso_o    = tx_shift_q[WIDTH-1];
      busy_o    = 1'b1;
    end
  end

  // Datapath next-state. A frame load happens on chip-select fall and on the
  // SCLK fall that follows the last rising edge of a frame. The load looks
  // at the buffer state before any same-cycle write, so a write into an
  // empty buffer during a load waits in the buffer for the following frame.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    reload_d   = reload_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_n_sync_i) begin
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_next;
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              reload_d   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall) begin
            if (reload_q) begin
              load     = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: ;
    endcase

    if (load) begin
      tx_shift_d = buf_full_q ? buf_q : '0;
      underrun_d = ~buf_full_q;
    end

    if (buf_full_q) begin
      if (load) buf_full_d = 1'b0;
    end else if (tx_valid_i) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end
  end

  // Datapath registers, including the registered SCLK/CS copies used for
  // edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      reload_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sclk_q     <= sclk_sync_i;
      cs_q       <= cs_n_sync_i;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      reload_q   <= reload_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_ready_o    = ~buf_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;

endmodule
